// File: rtl/vfd_tick_timer.sv
//------------------------------------------------------------------------------
// Module      : vfd_tick_timer
// Description : Programmable one-shot/periodic timer on us/ms tick strobes.
//               Optional tick-health checker enabled by VFD_TICK_CHECK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vfd_tick_timer #(
  parameter int CNT_W  = 16,
  parameter int US_DIV = 100
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             pluse_us,
  input  logic             pluse_ms,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_unit,
  input  logic             cfg_periodic,
  input  logic             clr_err,
  output logic             busy,
  output logic             expire,
  output logic [CNT_W-1:0] remain,
  output logic [7:0]       expire_cnt,
  output logic             err_tick
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic             r_unit;
  logic             r_periodic;
  logic             w_tick;
  logic             w_terminal;

  assign w_tick     = r_unit ? pluse_ms : pluse_us;
  assign w_terminal = (remain == CNT_W'(1));

  // Priority: stop > start > tick; a tick in the start cycle is never counted.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_unit     <= 1'b0;
      r_periodic <= 1'b0;
      busy       <= 1'b0;
      expire     <= 1'b0;
      remain     <= '0;
      expire_cnt <= '0;
    end else begin
      expire <= 1'b0;
      if (stop) begin
        if (r_state == ST_RUN) begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      end else if (start) begin
        r_len      <= cfg_len;
        r_unit     <= cfg_unit;
        r_periodic <= cfg_periodic;
        remain     <= cfg_len;
        if (cfg_len == '0) begin
          r_state    <= ST_IDLE;
          busy       <= 1'b0;
          expire     <= 1'b1;
          expire_cnt <= 8'd1;
        end else begin
          r_state    <= ST_RUN;
          busy       <= 1'b1;
          expire_cnt <= 8'd0;
        end
      end else if ((r_state == ST_RUN) && w_tick) begin
        if (w_terminal) begin
          expire     <= 1'b1;
          expire_cnt <= expire_cnt + 8'd1;
          if (r_periodic) begin
            remain <= r_len;
          end else begin
            remain  <= '0;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end else if (remain != '0) begin
          remain <= remain - CNT_W'(1);
        end
      end
    end
  end

`ifdef VFD_TICK_CHECK_EN
  localparam int c_gap_lim = 2 * US_DIV;
  localparam int c_gap_w   = $clog2(c_gap_lim + 1);

  logic [c_gap_w-1:0] r_gap;
  logic [10:0]        r_us_cnt;
  logic               r_ms_seen;
  logic [11:0]        w_us_total;
  logic               w_gap_err;
  logic               w_ms_err;

  // A us strobe coincident with the ms strobe belongs to the closing interval.
  assign w_us_total = {1'b0, r_us_cnt} + 12'(pluse_us);
  assign w_gap_err  = !pluse_us && (r_gap == c_gap_w'(c_gap_lim - 1));
  assign w_ms_err   = pluse_ms && r_ms_seen && (w_us_total != 12'd1000);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_gap     <= '0;
      r_us_cnt  <= '0;
      r_ms_seen <= 1'b0;
      err_tick  <= 1'b0;
    end else begin
      if (pluse_us) begin
        r_gap <= '0;
      end else if (r_gap != c_gap_w'(c_gap_lim)) begin
        r_gap <= r_gap + c_gap_w'(1);
      end
      if (pluse_ms) begin
        r_us_cnt  <= '0;
        r_ms_seen <= 1'b1;
      end else if (pluse_us && (r_us_cnt != '1)) begin
        r_us_cnt <= r_us_cnt + 11'd1;
      end
      err_tick <= (err_tick && !clr_err) || w_gap_err || w_ms_err;
    end
  end
`else
  logic w_unused;
  assign w_unused = clr_err ^ (US_DIV == 0);
  assign err_tick = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vfd_tick_timer.sv
//------------------------------------------------------------------------------
// Module      : tb_vfd_tick_timer
// Description : Self-checking bench for vfd_tick_timer against a tick-count model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vfd_tick_timer;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        pluse_us = 1'b0, pluse_ms = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        cfg_unit = 1'b0, cfg_periodic = 1'b0, clr_err = 1'b0;
  logic        busy, expire, err_tick;
  logic [15:0] remain;
  logic [7:0]  expire_cnt;

  int total = 0;
  int bad   = 0;

  // Model: ticks counted since the last load; remain/count derive arithmetically.
  int          m_len, m_ticks;
  logic        m_unit, m_per;
  logic        e_busy, e_expire;
  logic [15:0] e_remain;
  logic [7:0]  e_cnt;

  vfd_tick_timer #(.CNT_W(16), .US_DIV(100)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .pluse_ms(pluse_ms),
    .start(start), .stop(stop), .cfg_len(cfg_len), .cfg_unit(cfg_unit),
    .cfg_periodic(cfg_periodic), .clr_err(clr_err), .busy(busy), .expire(expire),
    .remain(remain), .expire_cnt(expire_cnt), .err_tick(err_tick)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_reset();
    m_len = 0; m_ticks = 0; m_unit = 1'b0; m_per = 1'b0;
    e_busy = 1'b0; e_expire = 1'b0; e_remain = '0; e_cnt = '0;
  endtask

  // Apply one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic drive(input logic s, input logic sp, input logic u, input logic m,
                       input logic [15:0] l, input logic un, input logic pe,
                       input logic c);
    start = s; stop = sp; pluse_us = u; pluse_ms = m;
    cfg_len = l; cfg_unit = un; cfg_periodic = pe; clr_err = c;
    e_expire = 1'b0;
    if (sp) begin
      e_busy = 1'b0;
    end else if (s) begin
      m_len = int'(l); m_unit = un; m_per = pe; m_ticks = 0;
      e_remain = l;
      if (l == 16'd0) begin
        e_busy = 1'b0; e_expire = 1'b1; e_cnt = 8'd1;
      end else begin
        e_busy = 1'b1; e_cnt = 8'd0;
      end
    end else if (e_busy && (m_unit ? m : u)) begin
      m_ticks++;
      e_remain = m_per ? 16'(m_len - (m_ticks % m_len)) : 16'(m_len - m_ticks);
      e_cnt    = 8'(m_ticks / m_len);
      if (m_ticks % m_len == 0) begin
        e_expire = 1'b1;
        if (!m_per) e_busy = 1'b0;
      end
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    total++;
    if ({busy, expire, remain, expire_cnt, err_tick} !== 27'd0) begin
      bad++;
      $display("FAIL reset: got b=%b e=%b r=%0d c=%0d err=%b, want all zero",
               busy, expire, remain, expire_cnt, err_tick);
    end
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk_sys); #1;
  endtask

  task automatic test_oneshot_us();
    int n_exp = 0;
    drive(1, 0, 0, 0, 16'd5, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 100; k++) begin
        if (k == 99) drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
        else         drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
        n_exp += int'(expire);
        total++;
        if ({busy, expire, remain, expire_cnt} !== {e_busy, e_expire, e_remain, e_cnt}) begin
          bad++;
          $display("FAIL oneshot t=%0d k=%0d: got b=%b e=%b r=%0d c=%0d want b=%b e=%b r=%0d c=%0d",
                   t, k, busy, expire, remain, expire_cnt, e_busy, e_expire, e_remain, e_cnt);
        end
      end
    end
    total++;
    if (n_exp != 1 || busy !== 1'b0 || expire_cnt !== 8'd1 || remain !== 16'd0) begin
      bad++;
      $display("FAIL oneshot_end: got n_exp=%0d b=%b c=%0d r=%0d want 1 0 1 0",
               n_exp, busy, expire_cnt, remain);
    end
  endtask

  task automatic test_periodic_ms();
    int n_exp = 0;
    drive(1, 0, 0, 0, 16'd3, 1, 1, 0);
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 20; k++) begin
        // us strobes must not be counted in ms mode
        drive(0, 0, (k % 4) == 1, k == 19, 16'd0, 0, 0, 0);
        n_exp += int'(expire);
        total++;
        if ({busy, expire, remain, expire_cnt} !== {e_busy, e_expire, e_remain, e_cnt}) begin
          bad++;
          $display("FAIL periodic t=%0d k=%0d: got b=%b e=%b r=%0d c=%0d want b=%b e=%b r=%0d c=%0d",
                   t, k, busy, expire, remain, expire_cnt, e_busy, e_expire, e_remain, e_cnt);
        end
      end
    end
    total++;
    if (n_exp != 3 || expire_cnt !== 8'd3 || busy !== 1'b1 || remain !== 16'd2) begin
      bad++;
      $display("FAIL periodic_end: got n_exp=%0d c=%0d b=%b r=%0d want 3 3 1 2",
               n_exp, expire_cnt, busy, remain);
    end
    drive(0, 1, 0, 0, 16'd0, 0, 0, 0);
  endtask

  task automatic test_stop_terminal();
    drive(1, 0, 0, 0, 16'd2, 0, 0, 0);
    drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
    drive(0, 1, 1, 0, 16'd0, 0, 0, 0);
    total++;
    if (busy !== 1'b0 || expire !== 1'b0 || remain !== 16'd1) begin
      bad++;
      $display("FAIL stop_terminal: got b=%b e=%b r=%0d want b=0 e=0 r=1", busy, expire, remain);
    end
    drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
    total++;
    if ({busy, expire, remain, expire_cnt} !== {e_busy, e_expire, e_remain, e_cnt} || expire !== 1'b0) begin
      bad++;
      $display("FAIL stop_after: got b=%b e=%b r=%0d c=%0d want b=0 e=0 r=1 c=%0d",
               busy, expire, remain, expire_cnt, e_cnt);
    end
  endtask

  task automatic test_zero_len_and_start_tick();
    drive(1, 0, 0, 0, 16'd0, 0, 1, 0);
    total++;
    if (expire !== 1'b1 || busy !== 1'b0 || expire_cnt !== 8'd1) begin
      bad++;
      $display("FAIL zero_len: got e=%b b=%b c=%0d want e=1 b=0 c=1", expire, busy, expire_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
      total++;
      if (busy !== 1'b0 || expire !== 1'b0 || expire_cnt !== 8'd1) begin
        bad++;
        $display("FAIL zero_len_idle k=%0d: got b=%b e=%b c=%0d want 0 0 1", k, busy, expire, expire_cnt);
      end
    end
    drive(1, 0, 1, 0, 16'd2, 0, 0, 0);
    total++;
    if (remain !== 16'd2 || busy !== 1'b1 || expire_cnt !== 8'd0) begin
      bad++;
      $display("FAIL start_tick: got r=%0d b=%b c=%0d want r=2 b=1 c=0", remain, busy, expire_cnt);
    end
    drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
    total++;
    if (remain !== 16'd1 || expire !== 1'b0) begin
      bad++;
      $display("FAIL start_tick_next: got r=%0d e=%b want r=1 e=0", remain, expire);
    end
    drive(0, 1, 0, 0, 16'd0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    int n_exp = 0;
    drive(1, 0, 0, 0, 16'd10, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
    total++;
    if (remain !== 16'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got r=%0d b=%b want r=7 b=1", remain, busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, expire, remain, expire_cnt, err_tick} !== 27'd0) begin
      bad++;
      $display("FAIL async_reset: got b=%b e=%b r=%0d c=%0d err=%b want all zero",
               busy, expire, remain, expire_cnt, err_tick);
    end
    pluse_us = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if (expire !== 1'b0 || busy !== 1'b0 || remain !== 16'd0) begin
      bad++;
      $display("FAIL in_reset: got e=%b b=%b r=%0d want 0 0 0", expire, busy, remain);
    end
    pluse_us = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk_sys); #1;
    drive(1, 0, 0, 0, 16'd3, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, k[0], 0, 16'd0, 0, 0, 0);
      n_exp += int'(expire);
      total++;
      if ({busy, expire, remain, expire_cnt} !== {e_busy, e_expire, e_remain, e_cnt}) begin
        bad++;
        $display("FAIL post_reset k=%0d: got b=%b e=%b r=%0d c=%0d want b=%b e=%b r=%0d c=%0d",
                 k, busy, expire, remain, expire_cnt, e_busy, e_expire, e_remain, e_cnt);
      end
    end
    total++;
    if (n_exp != 1) begin
      bad++;
      $display("FAIL post_reset_expires: got %0d want 1", n_exp);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            16'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 1'b0);
      total++;
      if ({busy, expire, remain, expire_cnt} !== {e_busy, e_expire, e_remain, e_cnt}) begin
        bad++;
        $display("FAIL random k=%0d: got b=%b e=%b r=%0d c=%0d want b=%b e=%b r=%0d c=%0d",
                 k, busy, expire, remain, expire_cnt, e_busy, e_expire, e_remain, e_cnt);
      end
    end
    drive(0, 1, 0, 0, 16'd0, 0, 0, 0);
  endtask

  task automatic test_tick_check();
`ifdef VFD_TICK_CHECK_EN
    // Regular us strobes, then a clear: error must drop.
    for (int k = 0; k < 10; k++) drive(0, 0, k[0], 0, 16'd0, 0, 0, 0);
    drive(0, 0, 0, 0, 16'd0, 0, 0, 1);
    total++;
    if (err_tick !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b want 0", err_tick);
    end
    repeat (250) drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
    total++;
    if (err_tick !== 1'b1) begin
      bad++;
      $display("FAIL err_gap: got %b want 1", err_tick);
    end
    repeat (5) drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
    total++;
    if (err_tick !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %b want 1", err_tick);
    end
    drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
    drive(0, 0, 0, 1, 16'd0, 0, 0, 0);
    drive(0, 0, 0, 0, 16'd0, 0, 0, 1);
    total++;
    if (err_tick !== 1'b0) begin
      bad++;
      $display("FAIL err_clear2: got %b want 0", err_tick);
    end
    for (int k = 0; k < 1000; k++) begin
      drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 16'd0, 0, 0, 0);
    total++;
    if (err_tick !== 1'b0) begin
      bad++;
      $display("FAIL err_ms_1000: got %b want 0", err_tick);
    end
    for (int k = 0; k < 999; k++) begin
      drive(0, 0, 1, 0, 16'd0, 0, 0, 0);
      drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 16'd0, 0, 0, 0);
    total++;
    if (err_tick !== 1'b1) begin
      bad++;
      $display("FAIL err_ms_999: got %b want 1", err_tick);
    end
`else
    drive(0, 0, 0, 0, 16'd0, 0, 0, 1);
    repeat (250) drive(0, 0, 0, 0, 16'd0, 0, 0, 0);
    total++;
    if (err_tick !== 1'b0) begin
      bad++;
      $display("FAIL err_disabled: got %b want 0", err_tick);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_oneshot_us();
    test_periodic_ms();
    test_stop_terminal();
    test_zero_len_and_start_tick();
    test_async_reset();
    test_random();
    test_tick_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
